// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: fruit placer FSM states, grid defaults,
// and the bit offsets of the coordinate fields inside a fruit_next candidate.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESEED = 2'd3
    } fp_state_e;

    localparam int unsigned GRID_W_DEF  = 32;
    localparam int unsigned GRID_H_DEF  = 24;
    localparam int unsigned COORD_W_DEF = 6;

    localparam int unsigned X_LSB = 0;
    localparam int unsigned Y_LSB = 8;

    localparam int unsigned RETRY_W = 5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fruit_cand_decode.sv
// Extracts x/y from a generator word and flags whether the cell lies on the grid.
// Purely combinational; also used by the VGA overlay.
module fruit_cand_decode
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W  = GRID_W_DEF,
    parameter int unsigned GRID_H  = GRID_H_DEF,
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic [31:0]        fruit_next_i,
    output logic [COORD_W-1:0] cand_x_o,
    output logic [COORD_W-1:0] cand_y_o,
    output logic               in_range_o
);

    // Bits outside the two coordinate fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^fruit_next_i;

    assign cand_x_o   = fruit_next_i[X_LSB +: COORD_W];
    assign cand_y_o   = fruit_next_i[Y_LSB +: COORD_W];
    assign in_range_o = (32'(cand_x_o) < GRID_W) && (32'(cand_y_o) < GRID_H);

endmodule

// File: rtl/fruit_placer.sv
// Picks a free, on-grid fruit cell from the generator stream, querying the snake
// occupancy responder. Optional idle relocation timer: FRUIT_TIMEOUT_EN.
module fruit_placer
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W      = GRID_W_DEF,
    parameter int unsigned GRID_H      = GRID_H_DEF,
    parameter int unsigned COORD_W     = COORD_W_DEF,
`ifdef FRUIT_TIMEOUT_EN
    parameter int unsigned RETRY_MAX   = 15,
    parameter int unsigned TIMEOUT_CYC = 50000000
`else
    parameter int unsigned RETRY_MAX   = 15
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        fruit_next,
    output logic               L_S,
    input  logic               eat,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] fruit_x,
    output logic [COORD_W-1:0] fruit_y,
    output logic               fruit_valid,
    output logic               placed,
    output logic [7:0]         reseed_cnt
);

    fp_state_e          state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               occ_req_q, occ_req_d;
    logic [COORD_W-1:0] occ_x_q, occ_x_d;
    logic [COORD_W-1:0] occ_y_q, occ_y_d;
    logic [COORD_W-1:0] fruit_x_q, fruit_x_d;
    logic [COORD_W-1:0] fruit_y_q, fruit_y_d;
    logic               fruit_valid_q, fruit_valid_d;
    logic               placed_q, placed_d;
    logic [7:0]         reseed_cnt_q, reseed_cnt_d;

    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic               cand_in_range;
    logic               retry_at_max;
    logic               timeout_evt;
    logic               eat_evt;

    fruit_cand_decode #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .COORD_W (COORD_W)
    ) u_decode (
        .fruit_next_i (fruit_next),
        .cand_x_o     (cand_x),
        .cand_y_o     (cand_y),
        .in_range_o   (cand_in_range)
    );

`ifdef FRUIT_TIMEOUT_EN
    logic [25:0] timer_q;

    always_ff @(posedge clk) begin
        if (rst || placed_q) begin
            timer_q <= '0;
        end else if (state_q == ST_IDLE) begin
            timer_q <= timer_q + 26'd1;
        end
    end

    assign timeout_evt = (state_q == ST_IDLE) && (timer_q == 26'(TIMEOUT_CYC - 1));
`else
    assign timeout_evt = 1'b0;
`endif

    // Checked before incrementing so the 5-bit retry counter can never wrap.
    assign retry_at_max = (32'(retry_q) >= RETRY_MAX);
    // An eat landing on the commit pulse is dropped: that fruit is brand new.
    assign eat_evt      = (eat || timeout_evt) && !placed_q;

    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        occ_req_d     = occ_req_q;
        occ_x_d       = occ_x_q;
        occ_y_d       = occ_y_q;
        fruit_x_d     = fruit_x_q;
        fruit_y_d     = fruit_y_q;
        fruit_valid_d = fruit_valid_q;
        placed_d      = 1'b0;
        reseed_cnt_d  = reseed_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (eat_evt) begin
                    fruit_valid_d = 1'b0;
                    retry_d       = '0;
                    state_d       = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (cand_in_range) begin
                    occ_x_d   = cand_x;
                    occ_y_d   = cand_y;
                    occ_req_d = 1'b1;
                    state_d   = ST_CHECK;
                end else if (retry_at_max) begin
                    state_d = ST_RESEED;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (occ_ack) begin
                    occ_req_d = 1'b0;
                    if (!occ_hit) begin
                        fruit_x_d     = occ_x_q;
                        fruit_y_d     = occ_y_q;
                        fruit_valid_d = 1'b1;
                        placed_d      = 1'b1;
                        state_d       = ST_IDLE;
                    end else if (retry_at_max) begin
                        state_d = ST_RESEED;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_RESEED: begin
                reseed_cnt_d = sat_inc8(reseed_cnt_q);
                retry_d      = '0;
                state_d      = ST_SAMPLE;
            end
            default: begin
                state_d = ST_SAMPLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SAMPLE;
            retry_q       <= '0;
            occ_req_q     <= 1'b0;
            occ_x_q       <= '0;
            occ_y_q       <= '0;
            fruit_x_q     <= '0;
            fruit_y_q     <= '0;
            fruit_valid_q <= 1'b0;
            placed_q      <= 1'b0;
            reseed_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            occ_req_q     <= occ_req_d;
            occ_x_q       <= occ_x_d;
            occ_y_q       <= occ_y_d;
            fruit_x_q     <= fruit_x_d;
            fruit_y_q     <= fruit_y_d;
            fruit_valid_q <= fruit_valid_d;
            placed_q      <= placed_d;
            reseed_cnt_q  <= reseed_cnt_d;
        end
    end

    assign L_S         = (state_q == ST_RESEED);
    assign occ_req     = occ_req_q;
    assign occ_x       = occ_x_q;
    assign occ_y       = occ_y_q;
    assign fruit_x     = fruit_x_q;
    assign fruit_y     = fruit_y_q;
    assign fruit_valid = fruit_valid_q;
    assign placed      = placed_q;
    assign reseed_cnt  = reseed_cnt_q;

endmodule

// File: doc/fruit_placer.md
Name: fruit_placer

Overview:
- Consumer side of the fruit generator interface.
- Samples `fruit_next` candidates from the FruitReg generator and decodes grid coordinates.
- Checks each candidate against the snake-body occupancy responder; retries on a hit or an out-of-range candidate.
- Presents one stable, validated fruit position to the game-logic and VGA layers, and re-places it each time the snake eats.

Parameters:
- GRID_W, 32, playfield width in cells; legal x is 0..GRID_W-1.
- GRID_H, 24, playfield height in cells; legal y is 0..GRID_H-1.
- COORD_W, 6, width of the x/y coordinate fields.
- RETRY_MAX, 15, failed candidates allowed per placement before a generator reseed.
- TIMEOUT_CYC, 50000000, uneaten-fruit relocation period in cycles (FRUIT_TIMEOUT_EN only).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- fruit_next, in, 32, candidate from the generator, which advances every clk.
- L_S, out, 1, generator load/shift select: 1 = load seed, 0 = shift.
- eat, in, 1, one-cycle pulse: the snake head entered the fruit cell.
- occ_req, out, 1, occupancy query request.
- occ_x, out, COORD_W, queried x.
- occ_y, out, COORD_W, queried y.
- occ_ack, in, 1, responder answer is valid this cycle.
- occ_hit, in, 1, the cell is occupied by the snake; valid only while occ_ack=1.
- fruit_x, out, COORD_W, placed fruit x.
- fruit_y, out, COORD_W, placed fruit y.
- fruit_valid, out, 1, fruit_x/fruit_y hold a validated position.
- placed, out, 1, one-cycle pulse when a new position is committed.
- reseed_cnt, out, 8, saturating count of reseed events.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=SAMPLE, fruit_x=0, fruit_y=0, fruit_valid=0.
  - placed=0, occ_req=0, occ_x=0, occ_y=0, L_S=0.
  - retry counter=0, reseed_cnt=0.
  - Placement starts automatically after reset.
- Decode:
  - cand_x = fruit_next[COORD_W-1:0].
  - cand_y = fruit_next[8+COORD_W-1:8].
  - A candidate is out of range when cand_x>=GRID_W or cand_y>=GRID_H.
- States:
  - IDLE: holds the fruit. eat=1 -> fruit_valid<=0, retry<=0, go to SAMPLE.
  - SAMPLE: register the decoded candidate.
    - Out of range -> retry+1, stay in SAMPLE.
    - In range -> drive occ_x/occ_y, assert occ_req, go to CHECK.
  - CHECK: hold occ_req=1 with stable occ_x/occ_y until occ_ack.
    - occ_ack & !occ_hit -> fruit_x/fruit_y<=cand, fruit_valid<=1, placed=1 for one cycle, occ_req<=0, go to IDLE.
    - occ_ack & occ_hit -> occ_req<=0, retry+1, go to SAMPLE.
  - RESEED: entered from SAMPLE or CHECK when retry would exceed RETRY_MAX.
    - L_S=1 for exactly one cycle, reseed_cnt+1 (saturates at 255), retry<=0, then SAMPLE.
- Latency:
  - Best case, ack arriving in the cycle after req: eat -> placed in 3 cycles.
  - No upper bound; the design relies on the reseed to break generator cycles.
- Boundary conditions:
  - eat outside IDLE is ignored; placement is already in progress.
  - eat coincident with placed: the fruit commits, and the eat is dropped.
  - occ_ack while occ_req=0 is ignored.
  - occ_ack asserted in the same cycle occ_req rises is accepted.
  - Synchronous rst in any state aborts the query: occ_req drops the next edge and fruit_valid clears.
  - retry is 5 bits and never wraps: the RESEED check precedes the increment.
  - Coordinates equal to GRID_W-1 or GRID_H-1 are legal.

Optional Feature:
- FRUIT_TIMEOUT_EN defined:
  - A 26-bit idle timer counts while in IDLE and clears on every placed.
  - Reaching TIMEOUT_CYC-1 acts as an internal eat: the fruit relocates, fruit_valid drops for the placement duration, and placed pulses.
  - An external eat in the same cycle as the timeout has priority, with identical effect.
- Undefined: the timer is not built, and the fruit stays put until eaten.

Decomposition:
- Package snake_pkg:
  - state encoding (IDLE, SAMPLE, CHECK, RESEED);
  - GRID_W/GRID_H defaults;
  - fruit_next field offsets (X_LSB=0, Y_LSB=8).
- One sub-module, fruit_cand_decode: combinational field extraction plus range check. It is reused by the VGA overlay.

Test Plan:
- Release reset; fruit_next=0x00000503; occ_ack next cycle with hit=0 -> fruit_x=3, fruit_y=5, fruit_valid=1, placed pulses once, L_S stays 0.
- In IDLE, pulse eat; fruit_next=0x00001F28 (x=40, out of range) for 2 cycles, then 0x00000A04 with no hit -> retry counts 2, fruit=(4,10).
- Responder returns occ_hit=1 for 16 consecutive candidates -> one-cycle L_S=1, reseed_cnt=1, retry=0; the next clear candidate is placed.
- Delay occ_ack by 7 cycles -> occ_req stays high and occ_x/occ_y stay stable throughout; eat pulses during the wait are ignored.
- Assert rst in CHECK -> next edge: occ_req=0, fruit_valid=0, state SAMPLE; the placement restarts after rst deasserts.
- With FRUIT_TIMEOUT_EN and TIMEOUT_CYC=100, no eat -> placed pulses 100 cycles after the prior placed, and the new position differs.
